// File: rtl/key_load_ctrl.sv
// Serial key loader that holds a locked FSM in reset until a full key is shifted in and applied.
// Optional KEY_PARITY_EN adds a key_par input checked against the shadow key before release.
module key_load_ctrl #(
  parameter int KEY_W     = 8,
  parameter int TIMEOUT   = 255,
  parameter int MAX_TRIES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_bit,
  input  logic             key_valid,
  output logic             key_ready,
  input  logic             relock,
`ifdef KEY_PARITY_EN
  input  logic             key_par,
`endif
  output logic [KEY_W-1:0] key_out,
  output logic             fsm_rst,
  output logic             fsm_en,
  output logic             key_done,
  output logic             busy,
  output logic             err,
  output logic             lockout
);

  localparam int CNT_W = $clog2(KEY_W + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam int TRY_W = 4;
  localparam logic [CNT_W-1:0] KEY_W_C   = CNT_W'(KEY_W);
  localparam logic [TO_W-1:0]  TO_LAST_C = TO_W'(TIMEOUT - 1);
  localparam logic [TRY_W-1:0] MAX_C     = TRY_W'(MAX_TRIES);

  typedef enum logic [2:0] {IDLE, LOAD, APPLY, RUN, LOCKOUT} state_t;

  state_t             state_reg, state_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [TO_W-1:0]    tcount_reg, tcount_next;
  logic [TRY_W-1:0]   tries_reg, tries_next;
  logic [KEY_W-1:0]   shadow_reg, shadow_next;
  logic [KEY_W-1:0]   key_out_reg, key_out_next;
  logic               key_ready_reg, key_ready_next;
  logic               fsm_rst_reg, fsm_rst_next;
  logic               fsm_en_reg, fsm_en_next;
  logic               key_done_reg, key_done_next;
  logic               busy_reg, busy_next;
  logic               err_reg, err_next;
  logic               lockout_reg, lockout_next;
  logic               xfer;
  logic               fail;
  logic               par_ok;
  logic [KEY_W-1:0]   wr_sel;

  // One-hot write strobe for the shadow bit addressed by the current count.
  generate
    for (genvar gi = 0; gi < KEY_W; gi++) begin : g_wr_sel
      assign wr_sel[gi] = (count_reg == CNT_W'(gi));
    end
  endgenerate

  assign xfer = key_valid & key_ready_reg;

`ifdef KEY_PARITY_EN
  logic par_reg, par_next;
  assign par_ok = ~((^shadow_reg) ^ par_reg);
`else
  assign par_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      count_reg     <= '0;
      tcount_reg    <= '0;
      tries_reg     <= '0;
      shadow_reg    <= '0;
      key_out_reg   <= '0;
      key_ready_reg <= 1'b0;
      fsm_rst_reg   <= 1'b1;
      fsm_en_reg    <= 1'b0;
      key_done_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      err_reg       <= 1'b0;
      lockout_reg   <= 1'b0;
`ifdef KEY_PARITY_EN
      par_reg       <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      count_reg     <= count_next;
      tcount_reg    <= tcount_next;
      tries_reg     <= tries_next;
      shadow_reg    <= shadow_next;
      key_out_reg   <= key_out_next;
      key_ready_reg <= key_ready_next;
      fsm_rst_reg   <= fsm_rst_next;
      fsm_en_reg    <= fsm_en_next;
      key_done_reg  <= key_done_next;
      busy_reg      <= busy_next;
      err_reg       <= err_next;
      lockout_reg   <= lockout_next;
`ifdef KEY_PARITY_EN
      par_reg       <= par_next;
`endif
    end
  end

  always_comb begin
    state_next   = state_reg;
    count_next   = count_reg;
    tcount_next  = tcount_reg;
    tries_next   = tries_reg;
    shadow_next  = shadow_reg;
    key_out_next = key_out_reg;
    err_next     = 1'b0;
    fail         = 1'b0;
`ifdef KEY_PARITY_EN
    par_next     = par_reg;
`endif

    case (state_reg)
      IDLE: begin
        key_out_next = '0;
        if (start) begin
          state_next  = LOAD;
          count_next  = '0;
          tcount_next = '0;
          shadow_next = '0;
        end
      end
      LOAD: begin
        if (relock) begin
          state_next  = IDLE;
          shadow_next = '0;
          count_next  = '0;
          tcount_next = '0;
        end else if (count_reg == KEY_W_C) begin
          // Key is driven while fsm_rst is still held so it is stable before release.
          state_next   = APPLY;
          key_out_next = par_ok ? shadow_reg : '0;
        end else if (xfer) begin
          for (int i = 0; i < KEY_W; i++) begin
            if (wr_sel[i]) shadow_next[i] = key_bit;
          end
          count_next  = count_reg + CNT_W'(1);
          tcount_next = '0;
`ifdef KEY_PARITY_EN
          par_next    = key_par;
`endif
        end else if (tcount_reg == TO_LAST_C) begin
          fail = 1'b1;
        end else begin
          tcount_next = tcount_reg + TO_W'(1);
        end
      end
      APPLY: begin
        if (!par_ok) begin
          fail = 1'b1;
        end else begin
          state_next = RUN;
          tries_next = '0;
        end
      end
      RUN: begin
        if (relock) begin
          state_next   = IDLE;
          key_out_next = '0;
          shadow_next  = '0;
        end
      end
      LOCKOUT: key_out_next = '0;
      default: state_next = IDLE;
    endcase

    if (fail) begin
      err_next     = 1'b1;
      shadow_next  = '0;
      key_out_next = '0;
      count_next   = '0;
      tcount_next  = '0;
      tries_next   = tries_reg + TRY_W'(1);
      state_next   = (tries_next >= MAX_C) ? LOCKOUT : IDLE;
    end

    // Registered outputs are derived from the state being entered.
    key_ready_next = (state_next == LOAD) && (count_next != KEY_W_C);
    fsm_rst_next   = (state_next != RUN);
    fsm_en_next    = (state_next == RUN);
    key_done_next  = (state_next == RUN);
    busy_next      = (state_next == LOAD) || (state_next == APPLY);
    lockout_next   = (state_next == LOCKOUT);
  end

  assign key_out   = key_out_reg;
  assign key_ready = key_ready_reg;
  assign fsm_rst   = fsm_rst_reg;
  assign fsm_en    = fsm_en_reg;
  assign key_done  = key_done_reg;
  assign busy      = busy_reg;
  assign err       = err_reg;
  assign lockout   = lockout_reg;

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed self-checking bench for key_load_ctrl (default parameters).
// Define KEY_PARITY_EN to also exercise the parity-checked build.
module tb_key_load_ctrl;

  logic       clk = 1'b0;
  logic       rst, start, key_bit, key_valid, relock, key_par;
  logic       key_ready, fsm_rst, fsm_en, key_done, busy, err, lockout;
  logic [7:0] key_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_load_ctrl #(.KEY_W(8), .TIMEOUT(255), .MAX_TRIES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_bit   (key_bit),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .relock    (relock),
`ifdef KEY_PARITY_EN
    .key_par   (key_par),
`endif
    .key_out   (key_out),
    .fsm_rst   (fsm_rst),
    .fsm_en    (fsm_en),
    .key_done  (key_done),
    .busy      (busy),
    .err       (err),
    .lockout   (lockout)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
    $display("check %-22s observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".key_out"},   {24'd0, key_out}, 32'h0);
    chk({tag, ".fsm_rst"},   {31'd0, fsm_rst}, 32'h1);
    chk({tag, ".fsm_en"},    {31'd0, fsm_en}, 32'h0);
    chk({tag, ".key_ready"}, {31'd0, key_ready}, 32'h0);
    chk({tag, ".key_done"},  {31'd0, key_done}, 32'h0);
    chk({tag, ".busy"},      {31'd0, busy}, 32'h0);
    chk({tag, ".err"},       {31'd0, err}, 32'h0);
    chk({tag, ".lockout"},   {31'd0, lockout}, 32'h0);
  endtask

  // Full load: start sample, 8 LSB-first transfers, then the APPLY cycle.
  task automatic load_key(input logic [7:0] v, input logic par);
    logic [7:0] kv;
    kv = v;
    key_par = par;
    start = 1'b1;
    tick();
    start = 1'b0;
    key_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      key_bit = kv[i];
      tick();
    end
    tick();
    tick();
  endtask

  // Start, 3 bits, then let the idle timeout expire.
  task automatic timeout_attempt(input string tag, input logic exp_lock);
    start = 1'b1;
    tick();
    start = 1'b0;
    key_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      key_bit = i[0];
      tick();
    end
    key_valid = 1'b0;
    repeat (254) tick();
    chk({tag, ".err_before"}, {31'd0, err}, 32'h0);
    tick();
    chk({tag, ".err_pulse"}, {31'd0, err}, 32'h1);
    chk({tag, ".lockout"}, {31'd0, lockout}, {31'd0, exp_lock});
    chk({tag, ".busy"}, {31'd0, busy}, 32'h0);
    tick();
    chk({tag, ".err_clear"}, {31'd0, err}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_bit = 1'b0; key_valid = 1'b0;
    relock = 1'b0; key_par = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst = 1'b0;
    tick();

    // 0xA5 with key_valid held: key_done rises exactly 10 cycles after the start sample.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("a5.key_ready", {31'd0, key_ready}, 32'h1);
    chk("a5.busy", {31'd0, busy}, 32'h1);
    key_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      logic [7:0] kv;
      kv = 8'hA5;
      key_bit = kv[i];
      key_par = 1'b0;
      tick();
    end
    chk("a5.ready_after_last", {31'd0, key_ready}, 32'h0);
    tick();
    chk("a5.apply_done", {31'd0, key_done}, 32'h0);
    chk("a5.apply_fsm_rst", {31'd0, fsm_rst}, 32'h1);
    chk("a5.apply_busy", {31'd0, busy}, 32'h1);
    tick();
    chk("a5.key_done", {31'd0, key_done}, 32'h1);
    chk("a5.key_out", {24'd0, key_out}, 32'hA5);
    chk("a5.fsm_rst", {31'd0, fsm_rst}, 32'h0);
    chk("a5.fsm_en", {31'd0, fsm_en}, 32'h1);
    chk("a5.busy_run", {31'd0, busy}, 32'h0);
    // key_valid and start are ignored in RUN
    start = 1'b1;
    key_bit = 1'b0;
    tick();
    tick();
    start = 1'b0;
    key_valid = 1'b0;
    chk("a5.run_hold", {24'd0, key_out}, 32'hA5);
    chk("a5.run_busy", {31'd0, busy}, 32'h0);

    // Relock from RUN, load 0x3C, relock, load 0x5A
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk("relock1.key_out", {24'd0, key_out}, 32'h0);
    chk("relock1.fsm_rst", {31'd0, fsm_rst}, 32'h1);
    load_key(8'h3C, 1'b0);
    chk("3c.key_out", {24'd0, key_out}, 32'h3C);
    chk("3c.key_done", {31'd0, key_done}, 32'h1);
    key_valid = 1'b0;
    relock = 1'b1;
    tick();
    relock = 1'b0;
    chk("relock2.key_out", {24'd0, key_out}, 32'h0);
    chk("relock2.fsm_rst", {31'd0, fsm_rst}, 32'h1);
    chk("relock2.key_done", {31'd0, key_done}, 32'h0);
    chk("relock2.fsm_en", {31'd0, fsm_en}, 32'h0);
    load_key(8'h5A, 1'b0);
    key_valid = 1'b0;
    chk("5a.key_out", {24'd0, key_out}, 32'h5A);
    chk("5a.key_done", {31'd0, key_done}, 32'h1);
    relock = 1'b1;
    tick();
    relock = 1'b0;

    // Reset mid-load, coincident with a valid bit
    start = 1'b1;
    tick();
    start = 1'b0;
    key_valid = 1'b1;
    key_bit = 1'b1;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    chk_reset_vals("midload_rst");
    rst = 1'b0;
    repeat (12) tick();
    key_valid = 1'b0;
    chk("midload.no_apply_done", {31'd0, key_done}, 32'h0);
    chk("midload.no_apply_key", {24'd0, key_out}, 32'h0);
    chk("midload.idle_busy", {31'd0, busy}, 32'h0);

    // Three timeouts -> lockout; start/relock ignored; rst clears it
    timeout_attempt("to1", 1'b0);
    timeout_attempt("to2", 1'b0);
    timeout_attempt("to3", 1'b1);
    chk("lock.fsm_rst", {31'd0, fsm_rst}, 32'h1);
    chk("lock.fsm_en", {31'd0, fsm_en}, 32'h0);
    start = 1'b1;
    relock = 1'b1;
    key_valid = 1'b1;
    tick();
    tick();
    start = 1'b0;
    relock = 1'b0;
    key_valid = 1'b0;
    chk("lock.sticky", {31'd0, lockout}, 32'h1);
    chk("lock.no_ready", {31'd0, key_ready}, 32'h0);
    chk("lock.no_busy", {31'd0, busy}, 32'h0);
    rst = 1'b1;
    tick();
    chk_reset_vals("lock_rst");
    rst = 1'b0;
    tick();

    // Relock abort does not count as a try; a successful load clears tries
    timeout_attempt("tr1", 1'b0);
    timeout_attempt("tr2", 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    key_valid = 1'b1;
    key_bit = 1'b1;
    repeat (2) tick();
    relock = 1'b1;
    tick();
    relock = 1'b0;
    key_valid = 1'b0;
    chk("abort.err", {31'd0, err}, 32'h0);
    chk("abort.busy", {31'd0, busy}, 32'h0);
    chk("abort.lockout", {31'd0, lockout}, 32'h0);
    load_key(8'h11, 1'b0);
    key_valid = 1'b0;
    chk("11.key_out", {24'd0, key_out}, 32'h11);
    relock = 1'b1;
    tick();
    relock = 1'b0;
    timeout_attempt("tr3", 1'b0);

`ifdef KEY_PARITY_EN
    // Parity mismatch: 0x01 with key_par=0 fails out of APPLY
    load_key(8'h01, 1'b0);
    key_valid = 1'b0;
    chk("par_bad.err", {31'd0, err}, 32'h1);
    chk("par_bad.key_out", {24'd0, key_out}, 32'h0);
    chk("par_bad.key_done", {31'd0, key_done}, 32'h0);
    chk("par_bad.busy", {31'd0, busy}, 32'h0);
    tick();
    load_key(8'h01, 1'b1);
    key_valid = 1'b0;
    chk("par_ok.key_out", {24'd0, key_out}, 32'h01);
    chk("par_ok.key_done", {31'd0, key_done}, 32'h1);
    chk("par_ok.err", {31'd0, err}, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
